fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core, sitting directly upstream of the decode stage that holds the immediate extender. Maintains the fetch PC and issues in-order word requests to instruction memory with a valid/ready handshake. Buffers up to two returned instructions and presents them through the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD). Honours decode stalls and execute-stage redirects (branch/jump), discarding wrong-path responses.

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, two-deep in-flight request tracking,
// two-entry instruction buffer and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemValid,
  input  logic [31:0] IMemRData,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pcf_r;
  logic [31:0] ifq_pc_r [2];
  logic [1:0]  out_cnt_r;
  logic [1:0]  drop_cnt_r;
  logic [1:0]  buf_cnt_r;
  logic [31:0] buf_instr_r [2];
  logic [31:0] buf_pc_r [2];
  logic [31:0] instr_d_r;
  logic [31:0] pc_d_r;
  logic [31:0] pc_plus4_d_r;
  logic        valid_d_r;

  logic [2:0]  occ_s;
  logic        credit_s;
  logic        req_s;
  logic        hs_s;
  logic        resp_s;
  logic        drop_s;
  logic        deliver_s;
  logic        load_s;
  logic        buf_pop_s;
  logic        bypass_s;
  logic        buf_push_s;
  logic [31:0] resp_pc_s;
  logic [31:0] target_s;
  logic [1:0]  out_after_pop_s;
  logic [1:0]  buf_after_pop_s;

  // Handshake, response and IF/ID load decode; credit uses registered counts only
  always_comb begin
    occ_s           = {1'b0, out_cnt_r} + {1'b0, buf_cnt_r};
    credit_s        = (occ_s < 3'd2);
    req_s           = credit_s & ~PCSrcE & ~reset;
    hs_s            = req_s & IMemReady;
    resp_s          = IMemValid & (out_cnt_r != 2'd0);
    resp_pc_s       = ifq_pc_r[0];
    drop_s          = resp_s & (drop_cnt_r != 2'd0);
    deliver_s       = resp_s & ~drop_s;
    load_s          = ~StallD | ~valid_d_r;
    buf_pop_s       = load_s & (buf_cnt_r != 2'd0);
    bypass_s        = load_s & (buf_cnt_r == 2'd0) & deliver_s;
    buf_push_s      = deliver_s & ~bypass_s;
    out_after_pop_s = out_cnt_r - {1'b0, resp_s};
    buf_after_pop_s = buf_cnt_r - {1'b0, buf_pop_s};
    target_s        = PCTargetE & 32'hFFFF_FFFC;
  end

  assign IMemReq  = req_s;
  assign IMemAddr = pcf_r;
  assign InstrD   = instr_d_r;
  assign PCD      = pc_d_r;
  assign PCPlus4D = pc_plus4_d_r;
  assign ValidD   = valid_d_r;

  // Fetch PC, in-flight PC queue and outstanding/drop counters
  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_r       <= RESET_PC;
      out_cnt_r   <= 2'd0;
      drop_cnt_r  <= 2'd0;
      ifq_pc_r[0] <= 32'h0000_0000;
      ifq_pc_r[1] <= 32'h0000_0000;
    end else begin
      if (resp_s) begin
        ifq_pc_r[0] <= ifq_pc_r[1];
      end
      // A push lands behind whatever survives this cycle's pop
      if (hs_s) begin
        ifq_pc_r[out_after_pop_s[0]] <= pcf_r;
      end
      out_cnt_r <= out_after_pop_s + {1'b0, hs_s};
      if (PCSrcE) begin
        pcf_r      <= target_s;
        drop_cnt_r <= out_after_pop_s;
      end else begin
        if (hs_s) begin
          pcf_r <= pcf_r + 32'd4;
        end
        drop_cnt_r <= drop_cnt_r - {1'b0, drop_s};
      end
    end
  end

  // Two-entry instruction buffer, head at index 0
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_cnt_r      <= 2'd0;
      buf_instr_r[0] <= 32'h0000_0000;
      buf_instr_r[1] <= 32'h0000_0000;
      buf_pc_r[0]    <= 32'h0000_0000;
      buf_pc_r[1]    <= 32'h0000_0000;
    end else if (PCSrcE) begin
      buf_cnt_r <= 2'd0;
    end else begin
      if (buf_pop_s) begin
        buf_instr_r[0] <= buf_instr_r[1];
        buf_pc_r[0]    <= buf_pc_r[1];
      end
      if (buf_push_s) begin
        buf_instr_r[buf_after_pop_s[0]] <= IMemRData;
        buf_pc_r[buf_after_pop_s[0]]    <= resp_pc_s;
      end
      buf_cnt_r <= buf_after_pop_s + {1'b0, buf_push_s};
    end
  end

  // IF/ID pipeline register: buffer head first, else same-cycle bypass
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d_r    <= 1'b0;
      instr_d_r    <= NOP;
      pc_d_r       <= 32'h0000_0000;
      pc_plus4_d_r <= 32'h0000_0000;
    end else if (PCSrcE) begin
      valid_d_r <= 1'b0;
    end else if (load_s) begin
      if (buf_cnt_r != 2'd0) begin
        valid_d_r    <= 1'b1;
        instr_d_r    <= buf_instr_r[0];
        pc_d_r       <= buf_pc_r[0];
        pc_plus4_d_r <= buf_pc_r[0] + 32'd4;
      end else if (deliver_s) begin
        valid_d_r    <= 1'b1;
        instr_d_r    <= IMemRData;
        pc_d_r       <= resp_pc_s;
        pc_plus4_d_r <= resp_pc_s + 32'd4;
      end else begin
        valid_d_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, redirect/reset
// sequences, randomized run against a queue-based model, and a PC-wrap instance.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        IMemReq, IMemReady, IMemValid, StallD, PCSrcE, ValidD;
  logic [31:0] IMemAddr, IMemRData, PCTargetE, InstrD, PCD, PCPlus4D;

  logic        w_reset = 1'b1;
  logic        w_req, w_valid, w_validd;
  logic [31:0] w_addr, w_rdata, w_instr, w_pcd, w_plus4;

  fetch_unit #(.RESET_PC(RST_PC)) u_dut (
    .clk(clk), .reset(reset), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemValid(IMemValid), .IMemRData(IMemRData),
    .StallD(StallD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(w_reset), .IMemReq(w_req), .IMemAddr(w_addr),
    .IMemReady(1'b1), .IMemValid(w_valid), .IMemRData(w_rdata),
    .StallD(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0000_0000),
    .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_plus4), .ValidD(w_validd)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t memq[$];

  // Reference model: outstanding requests tagged with a drop flag, and one
  // FIFO of delivered-but-unconsumed instructions.
  typedef struct { logic [31:0] pc; bit drop; } ofl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ofl_t        m_out[$];
  ent_t        m_buf[$];
  logic [31:0] m_pcf   = RST_PC;
  logic [31:0] m_instr = 32'h0000_0013;
  logic [31:0] m_pcd   = 32'h0000_0000;
  bit          m_valid = 1'b0;
  bit          m_req   = 1'b0;

  typedef struct { logic stall; logic req; logic [31:0] addr; logic valid; logic [31:0] pcd; } vec_t;
  vec_t tbl[13];

  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return ((w & 32'h0000_0FFF) << 20) | ((w & 32'h0000_001F) << 7) | 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive memory response for this cycle, then compare outputs to the model.
  task automatic drive_and_check();
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      IMemValid = 1'b1;
      IMemRData = imem(memq[0].addr);
      memq.delete(0);
    end else begin
      IMemValid = 1'b0;
      IMemRData = 32'hDEAD_BEEF;
    end
    #1;
    m_req = (m_out.size() + m_buf.size() < 2) && !PCSrcE && !reset;
    chk("IMemReq", IMemReq, m_req);
    if (m_req) chk("IMemAddr", IMemAddr, m_pcf);
    chk("ValidD", ValidD, m_valid);
    if (m_valid) begin
      chk("PCD", PCD, m_pcd);
      chk("InstrD", InstrD, m_instr);
      chk("PCPlus4D", PCPlus4D, m_pcd + 32'd4);
    end
  endtask

  // Record the handshake, take the clock edge, update the model.
  task automatic advance();
    bit   hs, deliv;
    ofl_t e;
    ent_t d;
    hs = m_req && IMemReady;
    if (IMemReq === 1'b1 && IMemReady) memq.push_back('{IMemAddr, cyc + lat});
    @(posedge clk);
    if (reset) begin
      m_out.delete(); m_buf.delete();
      m_pcf = RST_PC; m_valid = 1'b0; m_pcd = 32'h0; m_instr = 32'h0000_0013;
    end else begin
      deliv = 1'b0;
      if (IMemValid && m_out.size() > 0) begin
        e = m_out.pop_front();
        if (!e.drop) begin deliv = 1'b1; d = '{IMemRData, e.pc}; end
      end
      if (PCSrcE) begin
        foreach (m_out[i]) m_out[i].drop = 1'b1;
        m_buf.delete();
        m_valid = 1'b0;
        m_pcf = {PCTargetE[31:2], 2'b00};
      end else begin
        if (hs) begin m_out.push_back('{m_pcf, 1'b0}); m_pcf = m_pcf + 32'd4; end
        if (deliv) m_buf.push_back(d);
        if (!StallD || !m_valid) begin
          if (m_buf.size() > 0) begin
            d = m_buf.pop_front();
            m_valid = 1'b1; m_instr = d.instr; m_pcd = d.pc;
          end else begin
            m_valid = 1'b0;
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic fill_two();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_out.size() == 2) found = 1'b1;
      else begin drive_and_check(); advance(); end
    end
    chk("fill_wait", found, 1'b1);
  endtask

  initial begin
    bit got_req, got_v;
    int n_addr, n_v;
    bit          w_prev_hs;
    logic [31:0] w_prev_addr;
    logic [31:0] wexp [3];

    // Single-cycle memory, stall window in cycles 3..7
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[4]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[7]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[10] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[11] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[12] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};

    IMemReady = 1'b1; IMemValid = 1'b0; IMemRData = 32'h0;
    StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    w_valid = 1'b0; w_rdata = 32'h0;
    @(negedge clk);
    advance(); advance();
    drive_and_check();
    chk("rst_ValidD", ValidD, 1'b0);
    chk("rst_IMemReq", IMemReq, 1'b0);
    chk("rst_InstrD", InstrD, 32'h0000_0013);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    advance();

    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 13; i++) begin
      StallD = tbl[i].stall;
      drive_and_check();
      chk("tbl_req", IMemReq, tbl[i].req);
      if (tbl[i].req) chk("tbl_addr", IMemAddr, tbl[i].addr);
      chk("tbl_valid", ValidD, tbl[i].valid);
      if (tbl[i].valid) begin
        chk("tbl_pcd", PCD, tbl[i].pcd);
        chk("tbl_plus4", PCPlus4D, tbl[i].pcd + 32'd4);
        chk("tbl_instr", InstrD, imem(tbl[i].pcd));
      end
      advance();
    end

    // Redirect with two requests in flight on a 3-cycle memory
    lat = 3;
    fill_two();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0102;
    drive_and_check();
    advance();
    PCSrcE = 1'b0; PCTargetE = 32'h0;
    got_req = 1'b0; got_v = 1'b0;
    for (int k = 0; k < 30 && !(got_req && got_v); k++) begin
      drive_and_check();
      if (k == 0) chk("redir_validd", ValidD, 1'b0);
      if (!got_req && IMemReq) begin got_req = 1'b1; chk("redir_addr", IMemAddr, 32'h0000_0100); end
      if (!got_v && ValidD) begin got_v = 1'b1; chk("redir_pcd", PCD, 32'h0000_0100); end
      advance();
    end
    chk("redir_done", {30'h0, got_req, got_v}, 32'h3);

    // Reset with two outstanding; late responses arrive while nothing is in flight
    fill_two();
    reset = 1'b1;
    drive_and_check();
    advance();
    reset = 1'b0; IMemReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_and_check();
      if (k == 0) begin
        chk("rst2_req", IMemReq, 1'b1);
        chk("rst2_addr", IMemAddr, RST_PC);
      end
      chk("rst2_validd", ValidD, 1'b0);
      advance();
    end
    IMemReady = 1'b1;
    got_v = 1'b0;
    for (int k = 0; k < 20 && !got_v; k++) begin
      drive_and_check();
      if (ValidD) begin got_v = 1'b1; chk("rst2_pcd", PCD, RST_PC); end
      advance();
    end
    chk("rst2_done", got_v, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) lat = $urandom_range(1, 3);
      StallD    = ($urandom % 100) < 30;
      IMemReady = ($urandom % 100) < 70;
      PCSrcE    = ($urandom % 100) < 5;
      PCTargetE = $urandom;
      reset     = ($urandom % 100) < 1;
      drive_and_check();
      advance();
    end

    // Fetch-PC wrap from a high reset address
    reset = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; IMemReady = 1'b1;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    @(posedge clk); @(posedge clk); @(negedge clk);
    w_reset = 1'b0;
    n_addr = 0; n_v = 0; w_prev_hs = 1'b0; w_prev_addr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      w_valid = w_prev_hs;
      w_rdata = imem(w_prev_addr);
      #1;
      if (w_req && n_addr < 3) begin chk("wrap_addr", w_addr, wexp[n_addr]); n_addr++; end
      if (w_validd && n_v < 3) begin
        chk("wrap_pcd", w_pcd, wexp[n_v]);
        chk("wrap_plus4", w_plus4, wexp[n_v] + 32'd4);
        n_v++;
      end
      w_prev_hs = w_req;
      w_prev_addr = w_addr;
      @(posedge clk); @(negedge clk);
    end
    chk("wrap_naddr", n_addr, 3);
    chk("wrap_nvalid", n_v, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
